// File: rtl/morph_window_ctrl.sv
// morph_window_ctrl: builds a registered 3x3 binary window from a raster pixel stream,
// for a downstream erosion/dilation stage.
//
// Ports:
//   clk, rst_n              single rising-edge clock, asynchronous active-low reset
//   frame_start             one-cycle pulse, starts (or restarts) a frame at (0,0)
//   pix_en, pix_in          pixel qualifier and binary pixel (1 = background, 0 = foreground)
//   p11..p33                window taps; row 3 = current line, column 3 = newest pixel
//   data_en                 one strobe per accepted pixel, one cycle after acceptance
//   frame_done              coincides with data_en for the last pixel of a frame
//   overflow                sticky: a pixel arrived after the frame completed
module morph_window_ctrl #(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic pix_en,
  input  logic pix_in,
  output logic p11,
  output logic p12,
  output logic p13,
  output logic p21,
  output logic p22,
  output logic p23,
  output logic p31,
  output logic p32,
  output logic p33,
  output logic data_en,
  output logic frame_done,
  output logic overflow
);

  localparam int unsigned CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;

  // lb1_q holds line r-1, lb2_q holds line r-2, both indexed by column.
  logic [H_ACT-1:0] lb1_q;
  logic [H_ACT-1:0] lb2_q;

  logic          accept;
  logic [CW-1:0] acc_col;
  logic [RW-1:0] acc_row;
  logic          col_last;
  logic          row_last;
  logic          tap_top;
  logic          tap_mid;
  logic          left1_ok;
  logic          left2_ok;

  always_comb begin
    // A frame_start in the same cycle as a pixel makes that pixel (0,0) of the new frame.
    accept   = pix_en & (frame_start | (state_q == StActive));
    acc_col  = frame_start ? '0 : col_q;
    acc_row  = frame_start ? '0 : row_q;
    col_last = (acc_col == CW'(H_ACT - 1));
    row_last = (acc_row == RW'(V_ACT - 1));
    // Row padding also hides whatever a previous or aborted frame left in the buffers.
    tap_mid  = (acc_row != '0)     ? lb1_q[acc_col] : 1'b1;
    tap_top  = (acc_row > RW'(1))  ? lb2_q[acc_col] : 1'b1;
    left1_ok = (acc_col != '0);
    left2_ok = (acc_col > CW'(1));
  end

  // Line buffers carry no reset; stale contents are always masked by padding.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[acc_col] <= lb1_q[acc_col];
      lb1_q[acc_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      data_en    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      p11        <= 1'b0;
      p12        <= 1'b0;
      p13        <= 1'b0;
      p21        <= 1'b0;
      p22        <= 1'b0;
      p23        <= 1'b0;
      p31        <= 1'b0;
      p32        <= 1'b0;
      p33        <= 1'b0;
    end else begin
      data_en    <= accept;
      frame_done <= accept & row_last & col_last;

      if (frame_start) begin
        overflow <= 1'b0;
      end else if ((state_q == StDone) && pix_en) begin
        overflow <= 1'b1;
      end

      if (frame_start) begin
        state_q <= StActive;
        col_q   <= '0;
        row_q   <= '0;
      end

      if (accept) begin
        // The previous accepted pixel of this line sits in column 3 / column 2 already,
        // so the window just shifts left; the left edge pads with background.
        p13 <= tap_top;
        p23 <= tap_mid;
        p33 <= pix_in;
        p12 <= left1_ok ? p13 : 1'b1;
        p22 <= left1_ok ? p23 : 1'b1;
        p32 <= left1_ok ? p33 : 1'b1;
        p11 <= left2_ok ? p12 : 1'b1;
        p21 <= left2_ok ? p22 : 1'b1;
        p31 <= left2_ok ? p32 : 1'b1;

        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            row_q   <= '0;
            state_q <= StDone;
          end else begin
            row_q <= acc_row + RW'(1);
          end
        end else begin
          col_q <= acc_col + CW'(1);
          row_q <= acc_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_morph_window_ctrl.sv
// Bench for morph_window_ctrl with a 4x3 frame. A frame-level model stores accepted pixels
// by raster index and builds each expected window straight from that image with padding.
module tb_morph_window_ctrl;

  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic pix_en = 1'b0;
  logic pix_in = 1'b0;
  logic p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic data_en, frame_done, overflow;
  logic [8:0] win;

  always #5 clk = ~clk;

  morph_window_ctrl #(.H_ACT(H), .V_ACT(V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .pix_en     (pix_en),
    .pix_in     (pix_in),
    .p11        (p11),
    .p12        (p12),
    .p13        (p13),
    .p21        (p21),
    .p22        (p22),
    .p23        (p23),
    .p31        (p31),
    .p32        (p32),
    .p33        (p33),
    .data_en    (data_en),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  assign win = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

  int n_cmp = 0;
  int n_bad = 0;
  int fd_seen = 0;
  int de_seen = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [N-1:0] img;
  bit         m_open, m_done;
  int         m_n;
  logic       e_de, e_fd, e_ovf;
  logic [8:0] e_win;
  int         mn_now;
  bit         m_acc;
  logic [8:0] m_w;

  // Window for raster index n, where pixel n itself has value pix (not yet in im).
  function automatic logic [8:0] win_calc(input int n, input logic pix, input bit [N-1:0] im);
    logic [8:0] w;
    int r, c, rr, cc;
    r = n / H;
    c = n % H;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r - (2 - i);
        cc = c - (2 - j);
        if (rr < 0 || cc < 0) w[8 - (i * 3 + j)] = 1'b1;
        else if (rr == r && cc == c) w[8 - (i * 3 + j)] = pix;
        else w[8 - (i * 3 + j)] = im[rr * H + cc];
      end
    end
    return w;
  endfunction

  assign mn_now = frame_start ? 0 : m_n;
  assign m_acc  = pix_en && (frame_start || m_open);
  assign m_w    = win_calc(mn_now, pix_in, img);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open <= 1'b0;
      m_done <= 1'b0;
      m_n    <= 0;
      e_de   <= 1'b0;
      e_fd   <= 1'b0;
      e_ovf  <= 1'b0;
      e_win  <= '0;
    end else begin
      e_de <= m_acc;
      e_fd <= 1'b0;
      if (frame_start) e_ovf <= 1'b0;
      else if (pix_en && m_done) e_ovf <= 1'b1;
      if (frame_start) begin
        m_open <= 1'b1;
        m_done <= 1'b0;
        m_n    <= 0;
      end
      if (m_acc) begin
        img[mn_now] <= pix_in;
        e_win       <= m_w;
        if (mn_now == N - 1) begin
          e_fd   <= 1'b1;
          m_open <= 1'b0;
          m_done <= 1'b1;
          m_n    <= 0;
        end else begin
          m_n <= mn_now + 1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cycle", {data_en, frame_done, overflow, win}, {e_de, e_fd, e_ovf, e_win});
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic fs, input logic en, input logic v);
    frame_start = fs;
    pix_en      = en;
    pix_in      = v;
    @(negedge clk);
    fd_seen += int'(frame_done);
    de_seen += int'(data_en);
  endtask

  function automatic logic [8:0] dot_exp(input int n);
    case (n)
      5:       return 9'h1FE;
      6:       return 9'h1FD;
      7:       return 9'h1FB;
      9:       return 9'h1F7;
      10:      return 9'h1EF;
      11:      return 9'h1DF;
      default: return 9'h1FF;
    endcase
  endfunction

  initial begin
    logic v;

    @(negedge clk);
    check("reset_outputs", {data_en, frame_done, overflow, win}, 12'h000);
    rst_n = 1'b1;

    // Pixels before any frame_start are ignored.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("idle_no_de", data_en, 1'b0);
    end

    // All-zero frame.
    de_seen = 0;
    fd_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    check("zero_first_win", win, 9'h1FE);
    check("zero_first_de", data_en, 1'b1);
    for (int k = 1; k < N - 1; k++) step(1'b0, 1'b1, 1'b0);
    check("zero_no_early_fd", fd_seen, 0);
    step(1'b0, 1'b1, 1'b0);
    check("zero_last_win", win, 9'h000);
    check("zero_fd", frame_done, 1'b1);
    check("zero_de_count", de_seen, N);
    step(1'b0, 1'b0, 1'b0);
    check("zero_fd_one_cycle", frame_done, 1'b0);

    // Single foreground pixel at (1,1).
    for (int n = 0; n < N; n++) begin
      step(n == 0, 1'b1, (n == 5) ? 1'b0 : 1'b1);
      check($sformatf("dot_win_%0d", n), win, dot_exp(n));
    end

    // Overflow after completion, cleared by the next frame_start.
    step(1'b0, 1'b1, 1'b0);
    check("ovf_set", overflow, 1'b1);
    check("ovf_no_de", data_en, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("ovf_cleared", overflow, 1'b0);
    check("fs_only_no_de", data_en, 1'b0);

    // pix_en toggling.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, (k % 2) == 0, 1'($urandom_range(0, 1)));
      check($sformatf("toggle_de_%0d", k), data_en, (k % 2) == 0);
    end

    // Abort after 5 pixels, then a full new frame.
    step(1'b1, 1'b0, 1'b0);
    fd_seen = 0;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    v = 1'($urandom_range(0, 1));
    step(1'b1, 1'b1, v);
    check("abort_pad_win", win, {8'hFF, v});
    for (int k = 1; k < N; k++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    check("abort_fd_last", frame_done, 1'b1);
    check("abort_fd_count", fd_seen, 1);

    // Random traffic: frequent gaps, occasional restarts and overflow.
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
    end

    // Reset mid-frame.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    frame_start = 1'b0;
    pix_en      = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outputs", {data_en, frame_done, overflow, win}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      check("rst_ignore_de", data_en, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    check("rst_restart_de", data_en, 1'b1);
    check("rst_restart_win", win, 9'h1FE);
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
